cpc_pi_mailbox: RTL

CPLD block that bridges Z80 I/O cycles on the CPC expansion bus to the Raspberry Pi GPIO bus, in both directions.
- Z80 side: the block is an I/O responder at a data port and a status port.
- Pi side: the block is the initiator of a 4-phase REQ/ACK transmit handshake, and the responder to a Pi-initiated 4-phase receive handshake.
- One byte of buffering in each direction.

---
 rtl/cpc_pi_mailbox.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/cpc_pi_mailbox.sv
// cpc_pi_mailbox: one-byte-each-way mailbox between Z80 I/O on the CPC
// expansion bus and the Raspberry Pi GPIO bus (4-phase REQ/ACK handshakes).
//
// Ports:
//   CLK, RESET        - CPC bus clock; async active-high reset
//   A, D_IN           - Z80 address and write data
//   D_OUT, D_OE       - Z80 read data and bus drive enable
//   IOREQ_B, RD_B,
//   WR_B, M1_B        - Z80 strobes, active low
//   PI_DATA_OUT,
//   PI_TX_REQ,
//   PI_TX_ACK         - transmit handshake (block initiates)
//   PI_DATA_IN,
//   PI_RX_REQ,
//   PI_RX_ACK         - receive handshake (Pi initiates)
module cpc_pi_mailbox #(
    parameter logic [15:0] BASE_ADDR   = 16'hFD60,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] A,
    input  logic [7:0]  D_IN,
    output logic [7:0]  D_OUT,
    output logic        D_OE,
    input  logic        IOREQ_B,
    input  logic        RD_B,
    input  logic        WR_B,
    input  logic        M1_B,
    output logic [7:0]  PI_DATA_OUT,
    output logic        PI_TX_REQ,
    input  logic        PI_TX_ACK,
    input  logic [7:0]  PI_DATA_IN,
    input  logic        PI_RX_REQ,
    output logic        PI_RX_ACK
);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_REQ,
        TX_WAIT
    } tx_state_e;

    typedef enum logic {
        RX_IDLE,
        RX_ACK
    } rx_state_e;

    logic                   sel;
    logic                   rd;
    logic                   wr;
    logic                   wr_ev;
    logic                   pop;
    logic                   ack_s;
    logic                   req_s;
    logic                   tx_clr;

    logic                   wr_q,       wr_d;
    logic                   rd_q,       rd_d;
    logic                   rd_a0_q,    rd_a0_d;
    logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
    logic [SYNC_STAGES-1:0] req_sync_q, req_sync_d;
    logic [7:0]             tx_data_q,  tx_data_d;
    logic                   tx_full_q,  tx_full_d;
    logic                   tx_ovr_q,   tx_ovr_d;
    logic                   tx_req_q,   tx_req_d;
    tx_state_e              tx_state_q, tx_state_d;
    logic [7:0]             rx_data_q,  rx_data_d;
    logic                   rx_full_q,  rx_full_d;
    logic                   rx_ack_q,   rx_ack_d;
    rx_state_e              rx_state_q, rx_state_d;

    // IOREQ with M1 low is an interrupt acknowledge, never a port access.
    assign sel = !IOREQ_B && M1_B && (A[15:1] == BASE_ADDR[15:1]);
    assign rd  = sel && !RD_B;
    assign wr  = sel && !WR_B;

    // One write event per I/O cycle, however many wait states stretch it.
    assign wr_ev = wr && !wr_q;
    // Pop at the trailing edge of a data-port read.
    assign pop   = rd_q && !rd && !rd_a0_q;

    assign ack_s = ack_sync_q[SYNC_STAGES-1];
    assign req_s = req_sync_q[SYNC_STAGES-1];

    assign D_OE        = rd;
    assign D_OUT       = !rd  ? 8'h00 :
                         A[0] ? {5'b0, tx_ovr_q, rx_full_q, tx_full_q} :
                                rx_data_q;
    assign PI_DATA_OUT = tx_data_q;
    assign PI_TX_REQ   = tx_req_q;
    assign PI_RX_ACK   = rx_ack_q;

    always_comb begin
        wr_d       = wr;
        rd_d       = rd;
        rd_a0_d    = rd ? A[0] : rd_a0_q;
        ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], PI_TX_ACK};
        req_sync_d = {req_sync_q[SYNC_STAGES-2:0], PI_RX_REQ};
    end

    // Transmit side: Z80 fills the buffer, FSM hands it to the Pi.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_req_d   = tx_req_q;
        tx_clr     = 1'b0;
        unique case (tx_state_q)
            TX_IDLE: begin
                if (tx_full_q && !ack_s) begin
                    tx_req_d   = 1'b1;
                    tx_state_d = TX_REQ;
                end
            end
            TX_REQ: begin
                if (ack_s) begin
                    tx_req_d   = 1'b0;
                    tx_clr     = 1'b1;
                    tx_state_d = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (!ack_s) begin
                    tx_state_d = TX_IDLE;
                end
            end
            default: begin
                tx_req_d   = 1'b0;
                tx_state_d = TX_IDLE;
            end
        endcase

        tx_data_d = tx_data_q;
        tx_full_d = tx_clr ? 1'b0 : tx_full_q;
        tx_ovr_d  = tx_ovr_q;
        if (wr_ev && A[0] && D_IN[2]) begin
            tx_ovr_d = 1'b0;
        end
        // A buffer being emptied on this edge can take the new byte.
        if (wr_ev && !A[0]) begin
            if (!tx_full_q || tx_clr) begin
                tx_data_d = D_IN;
                tx_full_d = 1'b1;
            end else begin
                tx_ovr_d  = 1'b1;
            end
        end
    end

    // Receive side: the Pi is stalled while the Z80 has not read the byte.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_ack_d   = rx_ack_q;
        rx_data_d  = rx_data_q;
        rx_full_d  = pop ? 1'b0 : rx_full_q;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (req_s && !rx_full_q) begin
                    rx_data_d  = PI_DATA_IN;
                    rx_full_d  = 1'b1;
                    rx_ack_d   = 1'b1;
                    rx_state_d = RX_ACK;
                end
            end
            RX_ACK: begin
                if (!req_s) begin
                    rx_ack_d   = 1'b0;
                    rx_state_d = RX_IDLE;
                end
            end
            default: begin
                rx_ack_d   = 1'b0;
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            rd_a0_q    <= 1'b0;
            ack_sync_q <= '0;
            req_sync_q <= '0;
            tx_data_q  <= 8'h00;
            tx_full_q  <= 1'b0;
            tx_ovr_q   <= 1'b0;
            tx_req_q   <= 1'b0;
            tx_state_q <= TX_IDLE;
            rx_data_q  <= 8'h00;
            rx_full_q  <= 1'b0;
            rx_ack_q   <= 1'b0;
            rx_state_q <= RX_IDLE;
        end else begin
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            rd_a0_q    <= rd_a0_d;
            ack_sync_q <= ack_sync_d;
            req_sync_q <= req_sync_d;
            tx_data_q  <= tx_data_d;
            tx_full_q  <= tx_full_d;
            tx_ovr_q   <= tx_ovr_d;
            tx_req_q   <= tx_req_d;
            tx_state_q <= tx_state_d;
            rx_data_q  <= rx_data_d;
            rx_full_q  <= rx_full_d;
            rx_ack_q   <= rx_ack_d;
            rx_state_q <= rx_state_d;
        end
    end

endmodule
